// File: rtl/bsg_aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-256 encryptor.
// BSG_AES_KEYCHAIN_OUT_EN widens the output word to carry the round-key chain.
package bsg_aes_pkg;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NR      = 14;
   localparam int KEY_W   = 256;
   localparam int BLK_W   = 128;
   localparam int CHAIN_W = 1920;
   localparam int IN_W    = BLK_W + KEY_W;

`ifdef BSG_AES_KEYCHAIN_OUT_EN
   localparam int OUT_W = BLK_W + CHAIN_W;
`else
   localparam int OUT_W = BLK_W;
`endif

   function automatic logic [7:0] rcon(input logic [2:0] i);
      logic [7:0] r;
      r = 8'h00;
      unique case (i)
         3'd1: r = 8'h01;
         3'd2: r = 8'h02;
         3'd3: r = 8'h04;
         3'd4: r = 8'h08;
         3'd5: r = 8'h10;
         3'd6: r = 8'h20;
         3'd7: r = 8'h40;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

endpackage

// File: rtl/bsg_aes_encrypt_iter_if.sv
// valid/ready input and valid/yumi output bundle of the AES-256 encryptor.
// data_o width follows BSG_AES_KEYCHAIN_OUT_EN through bsg_aes_pkg::OUT_W.
interface bsg_aes_encrypt_iter_if;
   import bsg_aes_pkg::*;

   logic [IN_W-1:0]  data_i;
   logic             v_i;
   logic             ready_o;
   logic [OUT_W-1:0] data_o;
   logic             v_o;
   logic             yumi_i;

   modport master (
      output data_i, v_i, yumi_i,
      input  ready_o, data_o, v_o
   );

   modport slave (
      input  data_i, v_i, yumi_i,
      output ready_o, data_o, v_o
   );
endinterface

// File: rtl/bsg_aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (a^254) then affine map.
// No build options.
module bsg_aes_sbox
   import bsg_aes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Square-and-multiply; zero maps to zero as AES requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   logic [7:0] inv;

   assign inv = ginv(a_i);
   assign s_o = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

// File: rtl/bsg_aes_encrypt_iter.sv
// Iterative AES-256 encryptor, one round per cycle, on-the-fly key expansion.
// BSG_AES_KEYCHAIN_OUT_EN appends rk14..rk0 below the ciphertext on data_o.
module bsg_aes_encrypt_iter
   import bsg_aes_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    reset_i,
   bsg_aes_encrypt_iter_if.slave   io
);

   state_e             st_q, st_d;
   logic [3:0]         round_q, round_d;
   logic [BLK_W-1:0]   state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;

   logic [BLK_W-1:0]   sb, sr, mc, rnd;
   logic [31:0]        sw, temp;
   logic [31:0]        n0, n1, n2, n3;
   logic               last;
   logic               accept;

   assign last   = (round_q == 4'(NR));
   assign accept = (st_q == WAIT) && io.v_i;

   for (genvar i = 0; i < 16; i++) begin : g_sb
      bsg_aes_sbox u_sb (
         .a_i (state_q[127-8*i -: 8]),
         .s_o (sb[127-8*i -: 8])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_sw
      bsg_aes_sbox u_sw (
         .a_i (key_q[31-8*i -: 8]),
         .s_o (sw[31-8*i -: 8])
      );
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[127-8*(4*c+r) -: 8] =
            sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
      assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
   end

   // Window in round r is {rk(r-1), rk(r)}; the new half is rk(r+1).
   // Word index 4(r+1) is a multiple of 8 exactly when r is odd.
   assign temp = round_q[0]
               ? ({sw[23:0], sw[31:24]}
                  ^ {rcon(round_q[3:1] + 3'd1), 24'h0})
               : sw;

   assign n0  = key_q[255:224] ^ temp;
   assign n1  = key_q[223:192] ^ n0;
   assign n2  = key_q[191:160] ^ n1;
   assign n3  = key_q[159:128] ^ n2;

   assign rnd = (last ? sr : mc) ^ key_q[127:0];

   always_comb begin
      st_d    = st_q;
      round_d = round_q;
      state_d = state_q;
      key_d   = key_q;
      unique case (st_q)
         WAIT: begin
            if (io.v_i) begin
               state_d = io.data_i[383:256] ^ io.data_i[255:128];
               key_d   = io.data_i[255:0];
               round_d = 4'd1;
               st_d    = BUSY;
            end
         end
         BUSY: begin
            state_d = rnd;
            key_d   = {key_q[127:0], n0, n1, n2, n3};
            if (last) st_d = DONE;
            else      round_d = round_q + 4'd1;
         end
         DONE: begin
            if (io.yumi_i) begin
               st_d    = WAIT;
               round_d = 4'd0;
            end
         end
         default: st_d = WAIT;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         st_q    <= WAIT;
         round_q <= 4'd0;
         state_q <= '0;
         key_q   <= '0;
      end else begin
         st_q    <= st_d;
         round_q <= round_d;
         state_q <= state_d;
         key_q   <= key_d;
      end
   end

   assign io.ready_o = (st_q == WAIT);
   assign io.v_o     = (st_q == DONE);

`ifdef BSG_AES_KEYCHAIN_OUT_EN
   logic [CHAIN_W-1:0] chain_q, chain_d;

   always_comb begin
      chain_d = chain_q;
      if (accept)
         chain_d[127:0] = io.data_i[255:128];
      else if (st_q == BUSY)
         chain_d[{round_q, 7'd0} +: 128] = key_q[127:0];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) chain_q <= '0;
      else         chain_q <= chain_d;
   end

   assign io.data_o = {state_q, chain_q};
`else
   assign io.data_o = state_q;
`endif

endmodule

// File: tb/tb_bsg_aes_encrypt_iter.sv
// Scoreboard bench for bsg_aes_encrypt_iter: known-answer vectors, backpressure,
// back-to-back, mid-flight reset and handshake noise.
module tb_bsg_aes_encrypt_iter;
   import bsg_aes_pkg::*;

   localparam logic [255:0] C3_KEY =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
   localparam logic [127:0] C3_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] Z_CT    = 128'hdc95c078a2408989ad48a21492842087;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;

   bsg_aes_encrypt_iter_if io ();

   bsg_aes_encrypt_iter dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .io      (io)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];

   function automatic logic [127:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   function automatic logic [127:0] ct_out();
      return io.data_o[OUT_W-1 -: 128];
   endfunction

   task automatic accept(input logic [127:0] pt, input logic [255:0] key,
                         input logic [127:0] ct, input bit push);
      io.data_i = {pt, key};
      io.v_i    = 1'b1;
      if (push) exp_q.push_back(ct);
      @(negedge clk_i);
      io.v_i    = 1'b0;
      io.data_i = {12{$urandom()}};
   endtask

   task automatic wait_vo(output int n);
      n = 1;
      while (io.v_o !== 1'b1 && n < 40) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) @(negedge clk_i);
      checks++;
      if (io.v_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_v_o got %b want 0", io.v_o);
      end
      checks++;
      if (io.data_o !== '0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", ct_out());
      end
      reset_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (io.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", io.ready_o);
      end
   endtask

   task automatic test_fips_c3();
      int n;
      logic [127:0] e;
      checks++;
      if (io.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL c3_ready got %b want 1", io.ready_o);
      end
      accept(C3_PT, C3_KEY, C3_CT, 1'b1);
      wait_vo(n);
      checks++;
      if (n !== 15) begin
         errors++;
         $display("FAIL c3_latency got cycle %0d want 15", n);
      end
      checks++;
      if (io.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL c3_excl ready_o got %b want 0", io.ready_o);
      end
      e = pop_exp();
      checks++;
      if (ct_out() !== e) begin
         errors++;
         $display("FAIL c3_ct got %h want %h", ct_out(), e);
      end
`ifdef BSG_AES_KEYCHAIN_OUT_EN
      checks++;
      if (io.data_o[1919:1792] !== C3_RK14) begin
         errors++;
         $display("FAIL c3_rk14 got %h want %h", io.data_o[1919:1792], C3_RK14);
      end
      checks++;
      if (io.data_o[127:0] !== C3_RK0) begin
         errors++;
         $display("FAIL c3_rk0 got %h want %h", io.data_o[127:0], C3_RK0);
      end
`endif
      io.yumi_i = 1'b1;
      @(negedge clk_i);
      io.yumi_i = 1'b0;
      checks++;
      if (io.ready_o !== 1'b1 || io.v_o !== 1'b0) begin
         errors++;
         $display("FAIL c3_release ready/v got %b%b want 10", io.ready_o, io.v_o);
      end
   endtask

   task automatic test_zero();
      int n;
      logic [127:0] e;
      accept(128'h0, 256'h0, Z_CT, 1'b1);
      wait_vo(n);
      checks++;
      if (n !== 15) begin
         errors++;
         $display("FAIL zero_latency got cycle %0d want 15", n);
      end
      e = pop_exp();
      checks++;
      if (ct_out() !== e) begin
         errors++;
         $display("FAIL zero_ct got %h want %h", ct_out(), e);
      end
      io.yumi_i = 1'b1;
      @(negedge clk_i);
      io.yumi_i = 1'b0;
      checks++;
      if (io.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL zero_release ready got %b want 1", io.ready_o);
      end
   endtask

   task automatic test_backpressure();
      int n;
      int extra;
      logic [127:0] e;
      accept(C3_PT, C3_KEY, C3_CT, 1'b1);
      wait_vo(n);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (io.v_o !== 1'b1 || io.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hs[%0d] v/ready got %b%b want 10", i, io.v_o, io.ready_o);
         end
         checks++;
         if (ct_out() !== C3_CT) begin
            errors++;
            $display("FAIL bp_hold[%0d] got %h want %h", i, ct_out(), C3_CT);
         end
         io.v_i    = i[0];
         io.data_i = {12{$urandom()}};
         @(negedge clk_i);
      end
      io.v_i = 1'b0;
      e = pop_exp();
      checks++;
      if (ct_out() !== e) begin
         errors++;
         $display("FAIL bp_ct got %h want %h", ct_out(), e);
      end
      io.yumi_i = 1'b1;
      @(negedge clk_i);
      io.yumi_i = 1'b0;
      extra = 0;
      repeat (20) begin
         if (io.v_o === 1'b1 || io.ready_o !== 1'b1) extra++;
         @(negedge clk_i);
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL bp_ignored got %0d busy cycles want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [127:0] e;
      accept(C3_PT, C3_KEY, C3_CT, 1'b1);
      wait_vo(n);
      checks++;
      if (n !== 15) begin
         errors++;
         $display("FAIL b2b_first_latency got cycle %0d want 15", n);
      end
      e = pop_exp();
      checks++;
      if (ct_out() !== e) begin
         errors++;
         $display("FAIL b2b_first_ct got %h want %h", ct_out(), e);
      end
      io.yumi_i = 1'b1;
      io.v_i    = 1'b1;
      io.data_i = '0;
      exp_q.push_back(Z_CT);
      @(negedge clk_i);
      io.yumi_i = 1'b0;
      checks++;
      if (io.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready16 got %b want 1", io.ready_o);
      end
      @(negedge clk_i);
      io.v_i = 1'b0;
      checks++;
      if (io.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accepted got ready %b want 0", io.ready_o);
      end
      wait_vo(n);
      checks++;
      if (n !== 15) begin
         errors++;
         $display("FAIL b2b_second_latency got cycle %0d want 31", n + 16);
      end
      e = pop_exp();
      checks++;
      if (ct_out() !== e) begin
         errors++;
         $display("FAIL b2b_second_ct got %h want %h", ct_out(), e);
      end
      io.yumi_i = 1'b1;
      @(negedge clk_i);
      io.yumi_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      int pulses;
      accept(C3_PT, C3_KEY, C3_CT, 1'b0);
      repeat (6) @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      checks++;
      if (io.v_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_v_o got %b want 0", io.v_o);
      end
      checks++;
      if (io.data_o !== '0) begin
         errors++;
         $display("FAIL rst_mid_data got %h want 0", ct_out());
      end
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (io.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready got %b want 1", io.ready_o);
      end
      pulses = 0;
      repeat (20) begin
         if (io.v_o === 1'b1) pulses++;
         @(negedge clk_i);
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL rst_mid_no_vo got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_noise();
      int n;
      logic [127:0] e;
      io.yumi_i = 1'b1;
      @(negedge clk_i);
      io.yumi_i = 1'b0;
      checks++;
      if (io.ready_o !== 1'b1 || io.v_o !== 1'b0) begin
         errors++;
         $display("FAIL noise_wait ready/v got %b%b want 10", io.ready_o, io.v_o);
      end
      accept(C3_PT, C3_KEY, C3_CT, 1'b1);
      repeat (2) @(negedge clk_i);
      io.yumi_i = 1'b1;
      @(negedge clk_i);
      io.yumi_i = 1'b0;
      wait_vo(n);
      checks++;
      if (n !== 12) begin
         errors++;
         $display("FAIL noise_latency got cycle %0d want 15", n + 3);
      end
      e = pop_exp();
      checks++;
      if (ct_out() !== e) begin
         errors++;
         $display("FAIL noise_ct got %h want %h", ct_out(), e);
      end
      io.yumi_i = 1'b1;
      @(negedge clk_i);
      io.yumi_i = 1'b0;
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL noise_sb_left got %0d want 0", exp_q.size());
      end
   endtask

   initial begin
      io.v_i    = 1'b0;
      io.yumi_i = 1'b0;
      io.data_i = '0;
      test_reset();
      test_fips_c3();
      test_zero();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_fips_c3();
      test_noise();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
